// File: rtl/tle_tile_sequencer_if.sv
// Job command, issue, result and writeback signals of the tile sequencer.
// master: the sequencer itself; slave: job controller / operand fetch / engine / writeback side.
interface tle_tile_sequencer_if #(
  parameter int unsigned IDX_W = 8
);
  logic [IDX_W-1:0] cfg_m_i;
  logic [IDX_W-1:0] cfg_n_i;
  logic [IDX_W-1:0] cfg_k_i;
  logic             cfg_halved_i;
  logic             start_i;
  logic             busy_o;
  logic             done_o;
  logic             halved_o;
  logic             issue_valid_o;
  logic             issue_ready_i;
  logic [IDX_W-1:0] issue_m_o;
  logic [IDX_W-1:0] issue_n_o;
  logic [IDX_W-1:0] issue_k_o;
  logic             issue_first_o;
  logic             issue_last_o;
  logic             res_valid_i;
  logic             res_ready_o;
  logic             psum_we_o;
  logic             wb_valid_o;
  logic             wb_ready_i;
  logic [IDX_W-1:0] wb_m_o;
  logic [IDX_W-1:0] wb_n_o;

  modport master (
    input  cfg_m_i, cfg_n_i, cfg_k_i, cfg_halved_i, start_i,
    input  issue_ready_i, res_valid_i, wb_ready_i,
    output busy_o, done_o, halved_o,
    output issue_valid_o, issue_m_o, issue_n_o, issue_k_o, issue_first_o, issue_last_o,
    output res_ready_o, psum_we_o, wb_valid_o, wb_m_o, wb_n_o
  );

  modport slave (
    output cfg_m_i, cfg_n_i, cfg_k_i, cfg_halved_i, start_i,
    output issue_ready_i, res_valid_i, wb_ready_i,
    input  busy_o, done_o, halved_o,
    input  issue_valid_o, issue_m_o, issue_n_o, issue_k_o, issue_first_o, issue_last_o,
    input  res_ready_o, psum_we_o, wb_valid_o, wb_m_o, wb_n_o
  );
endinterface

// File: rtl/tle_tile_sequencer.sv
// Tile sequencer: walks the k/m/n loop nest of a tiled GEMM job, issues tile
// operations to the engine under an outstanding limit and the K-accumulation
// dependency, and retires results in order to partial-sum store or writeback.
module tle_tile_sequencer #(
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned MAX_OUT = 4
) (
  input logic                  clk_i,
  input logic                  rst_i,
  tle_tile_sequencer_if.master bus
);
  localparam int unsigned CNT_W = 3 * IDX_W;
  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cfg_m_q, cfg_n_q, cfg_k_q;
  logic             halved_q;
  logic [CNT_W-1:0] mn_q, total_q, issued_q, retired_q;
  logic [IDX_W-1:0] iss_m_q, iss_n_q, iss_k_q;
  logic [IDX_W-1:0] ret_m_q, ret_n_q, ret_k_q;
  logic [OUT_W-1:0] outstanding_q;

  logic start_acc, cfg_zero, active, ret_last;
  logic issue_valid, res_ready, issue_hs, retire_hs, last_issue, final_retire;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i) state_d = cfg_zero ? DONE : RUN;
      // the last issue and final retire coinciding skips DRAIN
      RUN:     if (last_issue) state_d = final_retire ? DONE : DRAIN;
      DRAIN:   if (final_retire) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and handshake decode
  always_comb begin
    active       = (state_q == RUN) || (state_q == DRAIN);
    start_acc    = (state_q == IDLE) && bus.start_i;
    cfg_zero     = (bus.cfg_m_i == '0) || (bus.cfg_n_i == '0) || (bus.cfg_k_i == '0);
    ret_last     = (ret_k_q == cfg_k_q - IDX_ONE);
    // issued-retired < M*N keeps (m,n,k) behind the retire of (m,n,k-1)
    issue_valid  = (state_q == RUN) && (outstanding_q < OUT_MAX) &&
                   ((issued_q - retired_q) < mn_q);
    res_ready    = active && (ret_last ? bus.wb_ready_i : 1'b1);
    issue_hs     = issue_valid && bus.issue_ready_i;
    retire_hs    = bus.res_valid_i && res_ready;
    last_issue   = issue_hs && (issued_q == total_q - CNT_ONE);
    final_retire = retire_hs && (retired_q == total_q - CNT_ONE);

    bus.busy_o        = active;
    bus.done_o        = (state_q == DONE);
    bus.halved_o      = halved_q;
    bus.issue_valid_o = issue_valid;
    bus.issue_m_o     = iss_m_q;
    bus.issue_n_o     = iss_n_q;
    bus.issue_k_o     = iss_k_q;
    bus.issue_first_o = (state_q == RUN) && (iss_k_q == '0);
    bus.issue_last_o  = (state_q == RUN) && (iss_k_q == cfg_k_q - IDX_ONE);
    bus.res_ready_o   = res_ready;
    bus.psum_we_o     = active && !ret_last && bus.res_valid_i;
    bus.wb_valid_o    = active && ret_last && bus.res_valid_i;
    bus.wb_m_o        = ret_m_q;
    bus.wb_n_o        = ret_n_q;
  end

  // Config latch, issue/retire loop counters and outstanding tracking
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_m_q       <= '0;
      cfg_n_q       <= '0;
      cfg_k_q       <= '0;
      halved_q      <= 1'b0;
      mn_q          <= '0;
      total_q       <= '0;
      issued_q      <= '0;
      retired_q     <= '0;
      iss_m_q       <= '0;
      iss_n_q       <= '0;
      iss_k_q       <= '0;
      ret_m_q       <= '0;
      ret_n_q       <= '0;
      ret_k_q       <= '0;
      outstanding_q <= '0;
    end else if (start_acc) begin
      cfg_m_q       <= bus.cfg_m_i;
      cfg_n_q       <= bus.cfg_n_i;
      cfg_k_q       <= bus.cfg_k_i;
      halved_q      <= bus.cfg_halved_i;
      mn_q          <= CNT_W'(bus.cfg_m_i) * CNT_W'(bus.cfg_n_i);
      total_q       <= CNT_W'(bus.cfg_m_i) * CNT_W'(bus.cfg_n_i) * CNT_W'(bus.cfg_k_i);
      issued_q      <= '0;
      retired_q     <= '0;
      iss_m_q       <= '0;
      iss_n_q       <= '0;
      iss_k_q       <= '0;
      ret_m_q       <= '0;
      ret_n_q       <= '0;
      ret_k_q       <= '0;
      outstanding_q <= '0;
    end else begin
      if (issue_hs) begin
        issued_q <= issued_q + CNT_ONE;
        if (iss_n_q == cfg_n_q - IDX_ONE) begin
          iss_n_q <= '0;
          if (iss_m_q == cfg_m_q - IDX_ONE) begin
            iss_m_q <= '0;
            iss_k_q <= (iss_k_q == cfg_k_q - IDX_ONE) ? '0 : iss_k_q + IDX_ONE;
          end else begin
            iss_m_q <= iss_m_q + IDX_ONE;
          end
        end else begin
          iss_n_q <= iss_n_q + IDX_ONE;
        end
      end
      if (retire_hs) begin
        retired_q <= retired_q + CNT_ONE;
        if (ret_n_q == cfg_n_q - IDX_ONE) begin
          ret_n_q <= '0;
          if (ret_m_q == cfg_m_q - IDX_ONE) begin
            ret_m_q <= '0;
            ret_k_q <= (ret_k_q == cfg_k_q - IDX_ONE) ? '0 : ret_k_q + IDX_ONE;
          end else begin
            ret_m_q <= ret_m_q + IDX_ONE;
          end
        end else begin
          ret_n_q <= ret_n_q + IDX_ONE;
        end
      end
      case ({issue_hs, retire_hs})
        2'b10:   outstanding_q <= outstanding_q + OUT_ONE;
        2'b01:   outstanding_q <= outstanding_q - OUT_ONE;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end
endmodule

// File: tb/tb_tle_tile_sequencer.sv
// Bench for tle_tile_sequencer: a job-level model (linear issue/retire
// indices) checked every cycle, an in-order engine with fixed latency, and
// directed jobs with hand-computed expectations.
module tb_tle_tile_sequencer;
  localparam int unsigned IDX_W   = 8;
  localparam int unsigned MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tle_tile_sequencer_if #(.IDX_W(IDX_W)) bus ();
  tle_tile_sequencer #(.IDX_W(IDX_W), .MAX_OUT(MAX_OUT)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct { int m; int n; int t; } eng_t;
  typedef struct { int m; int n; int k; bit f; bit l; int at; } iss_t;
  typedef struct { int m; int n; } wb_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  eng_t eng_q[$];
  bit   eng_en = 1'b1;
  int   eng_lat = 3;
  iss_t iss_log[$];
  int   ret_log[$];
  wb_t  wb_log[$];
  int   n_psum = 0;
  int   n_done = 0;
  int   done_at = -1;

  // model state
  bit m_busy = 0, m_done = 0, m_halved = 0;
  int m_M = 0, m_N = 0, m_K = 0, m_tot = 0, m_iss = 0, m_ret = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // in-order engine: each result becomes valid eng_lat cycles after its issue
  always @(negedge clk) begin
    if (eng_en && eng_q.size() > 0) bus.res_valid_i = (cyc >= eng_q[0].t);
    else                            bus.res_valid_i = 1'b0;
  end

  // compare process: checks every output each cycle, then advances the model
  always @(negedge clk) begin
    int mn, k, r;
    bit exp_iv, exp_rr, last_r;
    eng_t e;
    iss_t s;
    wb_t  w;
    #2;
    if (rst) begin
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_done", bus.done_o, 0);
      chk("rst_halved", bus.halved_o, 0);
      chk("rst_issue_valid", bus.issue_valid_o, 0);
      chk("rst_issue_m", bus.issue_m_o, 0);
      chk("rst_issue_n", bus.issue_n_o, 0);
      chk("rst_issue_k", bus.issue_k_o, 0);
      chk("rst_issue_first", bus.issue_first_o, 0);
      chk("rst_issue_last", bus.issue_last_o, 0);
      chk("rst_res_ready", bus.res_ready_o, 0);
      chk("rst_psum_we", bus.psum_we_o, 0);
      chk("rst_wb_valid", bus.wb_valid_o, 0);
      chk("rst_wb_m", bus.wb_m_o, 0);
      chk("rst_wb_n", bus.wb_n_o, 0);
      m_busy = 0; m_done = 0; m_halved = 0; m_iss = 0; m_ret = 0;
      eng_q.delete();
    end else begin
      mn     = m_busy ? m_M * m_N : 0;
      last_r = m_busy && ((m_ret / mn) == m_K - 1);
      exp_iv = m_busy && (m_iss < m_tot) && (m_iss - m_ret < int'(MAX_OUT)) && (m_iss - m_ret < mn);
      exp_rr = m_busy && (last_r ? bus.wb_ready_i : 1'b1);
      chk("busy", bus.busy_o, m_busy);
      chk("done", bus.done_o, m_done);
      chk("halved", bus.halved_o, m_halved);
      chk("issue_valid", bus.issue_valid_o, exp_iv);
      chk("res_ready", bus.res_ready_o, exp_rr);
      chk("psum_we", bus.psum_we_o, m_busy && !last_r && bus.res_valid_i);
      chk("wb_valid", bus.wb_valid_o, m_busy && last_r && bus.res_valid_i);
      if (exp_iv) begin
        k = m_iss / mn;
        r = m_iss % mn;
        chk("issue_m", bus.issue_m_o, r / m_N);
        chk("issue_n", bus.issue_n_o, r % m_N);
        chk("issue_k", bus.issue_k_o, k);
        chk("issue_first", bus.issue_first_o, k == 0);
        chk("issue_last", bus.issue_last_o, k == m_K - 1);
      end
      if (m_busy) begin
        r = m_ret % mn;
        chk("wb_m", bus.wb_m_o, r / m_N);
        chk("wb_n", bus.wb_n_o, r % m_N);
      end
      // environment bookkeeping from the handshakes the DUT actually performs
      if (bus.issue_valid_o === 1'b1 && bus.issue_ready_i) begin
        e.m = bus.issue_m_o; e.n = bus.issue_n_o; e.t = cyc + eng_lat;
        eng_q.push_back(e);
        s.m = bus.issue_m_o; s.n = bus.issue_n_o; s.k = bus.issue_k_o;
        s.f = bus.issue_first_o; s.l = bus.issue_last_o; s.at = cyc + 1;
        iss_log.push_back(s);
      end
      if (bus.res_valid_i && bus.res_ready_o === 1'b1) begin
        if (eng_q.size() > 0) begin
          chk("ret_order_m", bus.wb_m_o, eng_q[0].m);
          chk("ret_order_n", bus.wb_n_o, eng_q[0].n);
          void'(eng_q.pop_front());
        end
        ret_log.push_back(cyc + 1);
        if (bus.wb_valid_o === 1'b1) begin
          w.m = bus.wb_m_o; w.n = bus.wb_n_o;
          wb_log.push_back(w);
        end
      end
      if (bus.psum_we_o === 1'b1) n_psum++;
      if (bus.done_o === 1'b1) begin n_done++; done_at = cyc; end
      // model transition at the coming edge
      if (m_done) m_done = 0;
      else if (!m_busy && bus.start_i) begin
        m_M = bus.cfg_m_i; m_N = bus.cfg_n_i; m_K = bus.cfg_k_i;
        m_halved = bus.cfg_halved_i;
        m_tot = m_M * m_N * m_K;
        m_iss = 0; m_ret = 0;
        if (m_tot == 0) m_done = 1;
        else            m_busy = 1;
      end else if (m_busy) begin
        if (exp_iv && bus.issue_ready_i) m_iss++;
        if (bus.res_valid_i && exp_rr) m_ret++;
        if (m_ret == m_tot) begin m_busy = 0; m_done = 1; end
      end
    end
  end

  task automatic clear_logs();
    iss_log.delete(); ret_log.delete(); wb_log.delete();
    n_psum = 0; n_done = 0; done_at = -1;
  endtask

  task automatic start_job(input int m, input int n, input int k, input bit h);
    @(negedge clk);
    bus.cfg_m_i = 8'(m); bus.cfg_n_i = 8'(n); bus.cfg_k_i = 8'(k);
    bus.cfg_halved_i = h; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.cfg_m_i = '1; bus.cfg_n_i = '1; bus.cfg_k_i = '1; bus.cfg_halved_i = ~h;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int d0;
    d0 = n_done;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #3;
      if (n_done != d0) break;
    end
    chk(nm, n_done != d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wm, wn, got;
    int exp_m[4] = '{0, 0, 1, 1};
    int exp_n[4] = '{0, 1, 0, 1};
    bus.start_i = 1'b0; bus.cfg_m_i = '0; bus.cfg_n_i = '0; bus.cfg_k_i = '0;
    bus.cfg_halved_i = 1'b0; bus.issue_ready_i = 1'b1; bus.wb_ready_i = 1'b1;
    @(negedge clk); #1;
    chk("init_busy", bus.busy_o, 0);
    chk("init_issue_valid", bus.issue_valid_o, 0);
    chk("init_halved", bus.halved_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // 2x2x1, latency 3, always ready
    clear_logs();
    start_job(2, 2, 1, 1'b0);
    wait_done("t1_done_timeout", 200);
    chk("t1_issue_count", iss_log.size(), 4);
    chk("t1_wb_count", wb_log.size(), 4);
    chk("t1_psum_count", n_psum, 0);
    chk("t1_done_pulses", n_done, 1);
    for (int i = 0; i < 4; i++) begin
      if (i < iss_log.size()) begin
        chk("t1_iss_m", iss_log[i].m, exp_m[i]);
        chk("t1_iss_n", iss_log[i].n, exp_n[i]);
        chk("t1_iss_k", iss_log[i].k, 0);
        chk("t1_iss_first", iss_log[i].f, 1);
        chk("t1_iss_last", iss_log[i].l, 1);
      end
      if (i < wb_log.size()) begin
        chk("t1_wb_m", wb_log[i].m, exp_m[i]);
        chk("t1_wb_n", wb_log[i].n, exp_n[i]);
      end
    end
    if (ret_log.size() == 4) chk("t1_done_after_last_wb", done_at, ret_log[3]);
    else chk("t1_retire_count", ret_log.size(), 4);

    // 1x1x3: k-accumulation dependency
    clear_logs();
    start_job(1, 1, 3, 1'b1);
    wait_done("t2_done_timeout", 200);
    chk("t2_issue_count", iss_log.size(), 3);
    chk("t2_retire_count", ret_log.size(), 3);
    chk("t2_psum_count", n_psum, 2);
    chk("t2_wb_count", wb_log.size(), 1);
    chk("t2_halved_held", bus.halved_o, 1);
    if (iss_log.size() == 3 && ret_log.size() == 3) begin
      chk("t2_k1_after_k0_retire", iss_log[1].at > ret_log[0], 1);
      chk("t2_k2_after_k1_retire", iss_log[2].at > ret_log[1], 1);
      chk("t2_k0_first", iss_log[0].f, 1);
      chk("t2_k0_last", iss_log[0].l, 0);
      chk("t2_k1_first", iss_log[1].f, 0);
      chk("t2_k1_last", iss_log[1].l, 0);
      chk("t2_k2_first", iss_log[2].f, 0);
      chk("t2_k2_last", iss_log[2].l, 1);
    end

    // 4x4x1 with the engine stalled: outstanding limit
    clear_logs();
    eng_en = 1'b0;
    start_job(4, 4, 1, 1'b0);
    repeat (20) @(negedge clk);
    #3;
    chk("t3_issues_capped", iss_log.size(), 4);
    chk("t3_issue_valid_low", bus.issue_valid_o, 0);
    chk("t3_busy", bus.busy_o, 1);
    eng_en = 1'b1;
    wait_done("t3_done_timeout", 500);
    chk("t3_issue_total", iss_log.size(), 16);
    chk("t3_wb_total", wb_log.size(), 16);

    // 1x2x1 with writeback back-pressure
    clear_logs();
    bus.wb_ready_i = 1'b0;
    start_job(1, 2, 1, 1'b0);
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #3;
      if (bus.res_valid_i) begin got = 1; break; end
    end
    chk("t4_result_timeout", got, 1);
    wm = bus.wb_m_o; wn = bus.wb_n_o;
    chk("t4_wb_m_first", wm, 0);
    chk("t4_wb_n_first", wn, 0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_res_ready_low", bus.res_ready_o, 0);
      chk("t4_wb_valid_high", bus.wb_valid_o, 1);
      chk("t4_wb_m_stable", bus.wb_m_o, wm);
      chk("t4_wb_n_stable", bus.wb_n_o, wn);
      chk("t4_no_retire", ret_log.size(), 0);
      @(negedge clk); #3;
    end
    @(negedge clk);
    bus.wb_ready_i = 1'b1;
    wait_done("t4_done_timeout", 100);
    chk("t4_wb_count", wb_log.size(), 2);
    if (wb_log.size() == 2) begin
      chk("t4_wb1_m", wb_log[1].m, 0);
      chk("t4_wb1_n", wb_log[1].n, 1);
    end

    // zero-count job, then start ignored during RUN
    clear_logs();
    start_job(3, 2, 0, 1'b1);
    #1;
    chk("t5_zero_done", bus.done_o, 1);
    chk("t5_zero_busy", bus.busy_o, 0);
    chk("t5_zero_issue_valid", bus.issue_valid_o, 0);
    @(negedge clk); #3;
    chk("t5_zero_no_issue", iss_log.size(), 0);
    chk("t5_zero_halved", bus.halved_o, 1);
    clear_logs();
    start_job(2, 1, 2, 1'b0);
    @(negedge clk);
    bus.cfg_m_i = 8'd5; bus.cfg_n_i = 8'd5; bus.cfg_k_i = 8'd5;
    bus.cfg_halved_i = 1'b1; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_done("t5_done_timeout", 200);
    chk("t5_issue_count", iss_log.size(), 4);
    chk("t5_done_pulses", n_done, 1);
    chk("t5_halved_kept", bus.halved_o, 0);
    repeat (3) @(negedge clk);
    #3;
    chk("t5_no_restart", bus.busy_o, 0);

    // reset mid-RUN with two operations outstanding
    clear_logs();
    eng_en = 1'b0;
    start_job(2, 2, 2, 1'b1);
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #3;
      if (iss_log.size() >= 2) begin got = 1; break; end
    end
    chk("t6_two_issued_timeout", got, 1);
    @(negedge clk);
    bus.issue_ready_i = 1'b0;
    @(negedge clk);
    chk("t6_outstanding", iss_log.size(), 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", bus.busy_o, 0);
    chk("t6_rst_halved", bus.halved_o, 0);
    chk("t6_rst_issue_valid", bus.issue_valid_o, 0);
    chk("t6_rst_res_ready", bus.res_ready_o, 0);
    chk("t6_rst_wb_m", bus.wb_m_o, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.issue_ready_i = 1'b1;
    eng_en = 1'b1;
    clear_logs();
    start_job(1, 1, 1, 1'b0);
    wait_done("t6_done_timeout", 100);
    chk("t6_issue_count", iss_log.size(), 1);
    chk("t6_wb_count", wb_log.size(), 1);
    if (iss_log.size() == 1) begin
      chk("t6_first", iss_log[0].f, 1);
      chk("t6_last", iss_log[0].l, 1);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
